// File: rtl/mw_add_seq_if.sv
// Operand/result handshake bundle for mw_add_seq. The ovf member exists only
// when MW_ADD_SEQ_OVF_EN is defined.
interface mw_add_seq_if #(
  parameter int N     = 8,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef MW_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
`ifdef MW_ADD_SEQ_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
`ifdef MW_ADD_SEQ_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/mw_add_seq.sv
// Word-serial W-bit adder sequencer driving an external N-bit ripple adder,
// LS word first. Define MW_ADD_SEQ_OVF_EN to add the signed-overflow flag.
module mw_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mw_add_seq_if.slave  io,
  output logic [N-1:0] pa_a,
  output logic [N-1:0] pa_b,
  output logic         pa_c_in,
  input  logic [N-1:0] pa_y,
  input  logic         pa_c_out
);
  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
`ifdef MW_ADD_SEQ_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (io.in_valid)     next_state = BUSY;
      BUSY:    if (idx == LAST_IDX) next_state = DONE;
      DONE:    if (io.out_ready)    next_state = IDLE;
      default:                      next_state = IDLE;
    endcase
  end

  // Word datapath: capture on accept, then one adder word per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
`ifdef MW_ADD_SEQ_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (io.in_valid) begin
        a_reg <= io.a;
        b_reg <= io.b;
        carry <= io.c_in;
        idx   <= '0;
`ifdef MW_ADD_SEQ_OVF_EN
        a_msb <= io.a[W-1];
        b_msb <= io.b[W-1];
`endif
      end
    end else if (state == BUSY) begin
      sum_reg[int'(idx)*N +: N] <= pa_y;
      carry                     <= pa_c_out;
      if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
    end
  end

  // sum/c_out follow the registers directly; they are only meaningful in DONE.
  always_comb begin
    io.in_ready  = (state == IDLE);
    io.out_valid = (state == DONE);
    io.sum       = sum_reg;
    io.c_out     = carry;
    pa_a         = '0;
    pa_b         = '0;
    pa_c_in      = 1'b0;
    if (state == BUSY) begin
      pa_a    = a_reg[int'(idx)*N +: N];
      pa_b    = b_reg[int'(idx)*N +: N];
      pa_c_in = carry;
    end
`ifdef MW_ADD_SEQ_OVF_EN
    io.ovf = (state == DONE) && (a_msb == b_msb) && (sum_reg[W-1] != a_msb);
`endif
  end
endmodule
